// File: rtl/fft8_seq_engine.sv
// Sequential 8-point radix-2 DIT FFT/IFFT: one sample in, one butterfly, or one bin out per cycle.
// Optional macro FFT8_SEQ_SCALE_EN halves every butterfly output, which yields X/8 at the output.
module fft8_seq_engine #(
  parameter int unsigned DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          inverse,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+2:0] out_real,
  output logic [DW+2:0] out_imag,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned W = DW + 3;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_UNLOAD} state_t;

  state_t             state_q;
  logic [2:0]         n_q;
  logic [2:0]         bin_q;
  logic [1:0]         stage_q;
  logic [1:0]         pair_q;
  logic               inv_q;
  logic signed [W-1:0] mem_re_q [8];
  logic signed [W-1:0] mem_im_q [8];

  logic [2:0]          top_c, bot_c;
  logic [1:0]          k_c;
  logic signed [W-1:0] br_c, bi_c, ar_c, ai_c;
  logic signed [W:0]   s_c, d1_c, d2_c;
  logic signed [W-1:0] cm_s_c, cm_d1_c, cm_d2_c;
  logic signed [W-1:0] tr_c, ti_c;
  logic signed [W:0]   sum_re_c, sum_im_c, dif_re_c, dif_im_c;
  logic signed [W-1:0] new_top_re_c, new_top_im_c, new_bot_re_c, new_bot_im_c;

  // Multiply by ~0.7071 with shift-and-add, arithmetic shifts truncating toward -inf.
  function automatic logic signed [W-1:0] cmul(input logic signed [W:0] v);
    logic signed [W:0] r;
    r = (v >>> 1) + (v >>> 3) + (v >>> 4) + (v >>> 6) + (v >>> 8);
    return W'(r);
  endfunction

  // Butterfly addressing and twiddle exponent for the current (stage, pair).
  always_comb begin
    top_c = '0;
    k_c   = '0;
    case (stage_q)
      2'd0:    begin top_c = {pair_q, 1'b0};               k_c = 2'd0;              end
      2'd1:    begin top_c = {pair_q[1], 1'b0, pair_q[0]}; k_c = {pair_q[0], 1'b0}; end
      default: begin top_c = {1'b0, pair_q};               k_c = pair_q;            end
    endcase
    bot_c = top_c | (3'd1 << stage_q);
  end

  // Twiddle rotation W^k * x[bot]; the inverse direction uses the conjugate.
  always_comb begin
    ar_c    = mem_re_q[top_c];
    ai_c    = mem_im_q[top_c];
    br_c    = mem_re_q[bot_c];
    bi_c    = mem_im_q[bot_c];
    s_c     = {br_c[W-1], br_c} + {bi_c[W-1], bi_c};
    d1_c    = {br_c[W-1], br_c} - {bi_c[W-1], bi_c};
    d2_c    = {bi_c[W-1], bi_c} - {br_c[W-1], br_c};
    cm_s_c  = cmul(s_c);
    cm_d1_c = cmul(d1_c);
    cm_d2_c = cmul(d2_c);
    tr_c    = br_c;
    ti_c    = bi_c;
    case (k_c)
      2'd1: begin
        tr_c = inv_q ? cm_d1_c : cm_s_c;
        ti_c = inv_q ? cm_s_c  : cm_d2_c;
      end
      2'd2: begin
        tr_c = inv_q ? -bi_c : bi_c;
        ti_c = inv_q ? br_c  : -br_c;
      end
      2'd3: begin
        tr_c = inv_q ? -cm_s_c : cm_d2_c;
        ti_c = inv_q ? cm_d1_c : -cm_s_c;
      end
      default: ;
    endcase
    sum_re_c = {ar_c[W-1], ar_c} + {tr_c[W-1], tr_c};
    sum_im_c = {ai_c[W-1], ai_c} + {ti_c[W-1], ti_c};
    dif_re_c = {ar_c[W-1], ar_c} - {tr_c[W-1], tr_c};
    dif_im_c = {ai_c[W-1], ai_c} - {ti_c[W-1], ti_c};
`ifdef FFT8_SEQ_SCALE_EN
    new_top_re_c = W'(sum_re_c >>> 1);
    new_top_im_c = W'(sum_im_c >>> 1);
    new_bot_re_c = W'(dif_re_c >>> 1);
    new_bot_im_c = W'(dif_im_c >>> 1);
`else
    new_top_re_c = W'(sum_re_c);
    new_top_im_c = W'(sum_im_c);
    new_bot_re_c = W'(dif_re_c);
    new_bot_im_c = W'(dif_im_c);
`endif
  end

  // Control FSM, sample buffer and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_LOAD;
      n_q       <= '0;
      bin_q     <= '0;
      stage_q   <= '0;
      pair_q    <= '0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            mem_re_q[{n_q[0], n_q[1], n_q[2]}] <= W'($signed(in_real));
            mem_im_q[{n_q[0], n_q[1], n_q[2]}] <= W'($signed(in_imag));
            if (n_q == 3'd0) inv_q <= inverse;
            n_q <= n_q + 3'd1;
            if (n_q == 3'd7) begin
              state_q  <= S_CALC;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              stage_q  <= '0;
              pair_q   <= '0;
            end
          end
        end
        S_CALC: begin
          mem_re_q[top_c] <= new_top_re_c;
          mem_im_q[top_c] <= new_top_im_c;
          mem_re_q[bot_c] <= new_bot_re_c;
          mem_im_q[bot_c] <= new_bot_im_c;
          pair_q <= pair_q + 2'd1;
          if (pair_q == 2'd3) stage_q <= stage_q + 2'd1;
          // Final butterfly touches bins 3/7, so bin 0 is already settled here.
          if (stage_q == 2'd2 && pair_q == 2'd3) begin
            state_q   <= S_UNLOAD;
            bin_q     <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_real  <= mem_re_q[0];
            out_imag  <= mem_im_q[0];
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (bin_q == 3'd7) begin
              state_q   <= S_LOAD;
              n_q       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              bin_q    <= bin_q + 3'd1;
              out_real <= mem_re_q[bin_q + 3'd1];
              out_imag <= mem_im_q[bin_q + 3'd1];
              out_last <= (bin_q == 3'd6);
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_seq_engine.sv
// Self-checking bench for fft8_seq_engine: reference FFT model, directed frames and random traffic.
module tb_fft8_seq_engine;

  localparam int DW = 16;

  typedef int frame_t [8];

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real, in_imag;
  logic          inverse;
  logic          out_valid;
  logic          out_ready;
  logic [DW+2:0] out_real, out_imag;
  logic          out_last;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rx_idx = 0;
  int or_mode = 0;
  int stall = 0;
  int exp_re[$];
  int exp_im[$];
  bit prev_v = 1'b0, prev_acc = 1'b0;
  int prev_re, prev_im;

  fft8_seq_engine #(.DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int cm(int v);
    return (v >>> 1) + (v >>> 3) + (v >>> 4) + (v >>> 6) + (v >>> 8);
  endfunction

  // Complex product (a+jb)*W8^k, W8 = exp(-j*pi/4) for FFT, conjugate for IFFT.
  function automatic void twiddle(input int a, input int b, input int k, input bit inv,
                                  output int r, output int i);
    case (k)
      0: begin r = a; i = b; end
      1: if (inv) begin r = cm(a - b); i = cm(a + b); end
         else     begin r = cm(a + b); i = cm(b - a); end
      2: if (inv) begin r = -b; i = a; end
         else     begin r = b;  i = -a; end
      default: if (inv) begin r = -cm(a + b); i = cm(a - b); end
               else     begin r = cm(b - a);  i = -cm(a + b); end
    endcase
  endfunction

  // Textbook iterative DIT FFT on plain integers.
  function automatic void fft_model(input frame_t xr, input frame_t xi, input bit inv,
                                    output frame_t yr, output frame_t yi);
    frame_t ar, ai;
    for (int n = 0; n < 8; n++) begin
      int rev;
      rev = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      ar[rev] = xr[n];
      ai[rev] = xi[n];
    end
    for (int span = 1; span < 8; span = span * 2) begin
      for (int base = 0; base < 8; base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          int top, bot, tr, ti, ur, ui;
          top = base + j;
          bot = top + span;
          twiddle(ar[bot], ai[bot], j * (4 / span), inv, tr, ti);
          ur = ar[top];
          ui = ai[top];
          ar[top] = ur + tr; ai[top] = ui + ti;
          ar[bot] = ur - tr; ai[bot] = ui - ti;
`ifdef FFT8_SEQ_SCALE_EN
          ar[top] = ar[top] >>> 1; ai[top] = ai[top] >>> 1;
          ar[bot] = ar[bot] >>> 1; ai[bot] = ai[bot] >>> 1;
`endif
        end
      end
    end
    yr = ar;
    yi = ai;
  endfunction

  // Output compare: scoreboard order, stall stability, and mutual exclusion with in_ready.
  always @(negedge CLK) begin
    if (RST) begin
      prev_v = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (out_valid) begin
        if (prev_v && !prev_acc) begin
          chk("hold_re", $signed(out_real), prev_re);
          chk("hold_im", $signed(out_imag), prev_im);
        end
        chk("in_ready_during_unload", int'(in_ready), 0);
        if (out_ready) begin
          if (exp_re.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bin: got bin with no expectation queued");
          end else begin
            chk($sformatf("bin%0d_re", rx_idx), $signed(out_real), exp_re.pop_front());
            chk($sformatf("bin%0d_im", rx_idx), $signed(out_imag), exp_im.pop_front());
            chk($sformatf("bin%0d_last", rx_idx), int'(out_last), (rx_idx == 7) ? 1 : 0);
            rx_idx = (rx_idx + 1) % 8;
          end
        end
      end else begin
        chk("last_without_valid", int'(out_last), 0);
      end
      prev_v   = out_valid;
      prev_acc = out_valid && out_ready;
      prev_re  = $signed(out_real);
      prev_im  = $signed(out_imag);
    end
  end

  // out_ready policy: always ready, random, or a 5-cycle stall on bin 3.
  always @(posedge CLK) begin
    #1;
    case (or_mode)
      1: out_ready = ($urandom_range(3, 0) != 0);
      2: if (out_valid && rx_idx == 3 && stall < 5) begin
           out_ready = 1'b0;
           stall++;
         end else begin
           out_ready = 1'b1;
         end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send_frame(input frame_t xr, input frame_t xi, input bit inv, input bit gaps,
                            output int t_acc);
    frame_t yr, yi;
    int i = 0;
    int budget = 0;
    bit acc;
    t_acc = 0;
    fft_model(xr, xi, inv, yr, yi);
    for (int k = 0; k < 8; k++) begin
      exp_re.push_back(yr[k]);
      exp_im.push_back(yi[k]);
    end
    while (i < 8) begin
      if (gaps && $urandom_range(2, 0) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_real  = DW'(xr[i]);
        in_imag  = DW'(xi[i]);
        inverse  = (i == 0) ? inv : 1'($urandom);
      end
      acc = in_valid && in_ready;
      @(posedge CLK); #1;
      if (acc) begin
        if (i == 7) t_acc = cyc - 1;
        i++;
      end
      budget++;
      if (budget > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: accepted %0d samples, expected 8", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    while ((exp_re.size() != 0 || !in_ready) && budget < 400) begin
      @(posedge CLK); #1;
      budget++;
    end
    chk("frame_drain_timeout", budget < 400 ? 1 : 0, 1);
  endtask

  function automatic void rand_frame(output frame_t xr, output frame_t xi);
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(32768, 0)) - 16384;
      xi[k] = int'($urandom_range(32768, 0)) - 16384;
    end
  endfunction

`ifdef FFT8_SEQ_SCALE_EN
  localparam int IMP_BIN = 32;
  localparam int DC_BIN0 = 256;
`else
  localparam int IMP_BIN = 256;
  localparam int DC_BIN0 = 2048;
`endif

  initial begin
    frame_t xr, xi, yr, yi, zero;
    int t, budget;
    zero = '{0, 0, 0, 0, 0, 0, 0, 0};
    RST = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; inverse = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_real", int'(out_real), 0);
    chk("rst_out_imag", int'(out_imag), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Impulse at n=0, plus first-bin latency and in_ready return.
    xr = zero; xi = zero; xr[0] = 256;
    fft_model(xr, xi, 1'b0, yr, yi);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("model_imp_re%0d", k), yr[k], IMP_BIN);
      chk($sformatf("model_imp_im%0d", k), yi[k], 0);
    end
    send_frame(xr, xi, 1'b0, 1'b0, t);
    chk("busy_in_calc", int'(busy), 1);
    budget = 0;
    while (!out_valid && budget < 40) begin @(posedge CLK); #1; budget++; end
    chk("first_bin_latency", cyc - t, 13);
    budget = 0;
    while (!in_ready && budget < 40) begin @(posedge CLK); #1; budget++; end
    chk("in_ready_return", cyc - t, 21);
    wait_done();

    // DC frame.
    xr = '{256, 256, 256, 256, 256, 256, 256, 256}; xi = zero;
    fft_model(xr, xi, 1'b0, yr, yi);
    chk("model_dc_bin0", yr[0], DC_BIN0);
    chk("model_dc_bin5", yr[5], 0);
    send_frame(xr, xi, 1'b0, 1'b0, t);
    wait_done();

    // Shifted impulse, forward and inverse.
    xr = zero; xi = zero; xr[1] = 256;
    fft_model(xr, xi, 1'b0, yr, yi);
`ifndef FFT8_SEQ_SCALE_EN
    chk("model_sh_x1_re", yr[1], 181);  chk("model_sh_x1_im", yi[1], -181);
    chk("model_sh_x2_im", yi[2], -256); chk("model_sh_x3_re", yr[3], -181);
    chk("model_sh_x4_re", yr[4], -256);
`endif
    send_frame(xr, xi, 1'b0, 1'b1, t);
    wait_done();
    fft_model(xr, xi, 1'b1, yr, yi);
`ifndef FFT8_SEQ_SCALE_EN
    chk("model_ish_x1_re", yr[1], 181); chk("model_ish_x1_im", yi[1], 181);
    chk("model_ish_x2_im", yi[2], 256);
`endif
    send_frame(xr, xi, 1'b1, 1'b0, t);
    wait_done();

    // Backpressure on bin 3.
    or_mode = 2; stall = 0;
    rand_frame(xr, xi);
    send_frame(xr, xi, 1'b0, 1'b0, t);
    wait_done();
    chk("bp_stall_cycles", stall, 5);
    or_mode = 0;

    // Reset during CALC cycle 6, then a clean impulse frame.
    rand_frame(xr, xi);
    send_frame(xr, xi, 1'b1, 1'b0, t);
    repeat (5) begin @(posedge CLK); #1; end
    RST = 1'b1;
    exp_re.delete(); exp_im.delete(); rx_idx = 0;
    @(posedge CLK); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    RST = 1'b0;
    xr = zero; xi = zero; xr[0] = 256;
    send_frame(xr, xi, 1'b0, 1'b0, t);
    wait_done();

    // Random frames with input gaps and random downstream readiness.
    or_mode = 1;
    for (int f = 0; f < 25; f++) begin
      rand_frame(xr, xi);
      send_frame(xr, xi, 1'($urandom), 1'b1, t);
    end
    wait_done();
    or_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
